// File: rtl/io_display_ctrl.sv
// Multi-channel seven-segment display controller: round-robin sequential double-dabble
// (or hex pass-through) per channel, then time-multiplexed scan onto one segment bus.
module io_display_ctrl #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned CH_DIGITS   = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                          sys_clk_in,
    input  logic                          sys_rst_n,
    input  logic [NUM_CH*DATA_W-1:0]      ch_data,
    input  logic                          hex_mode,
    input  logic                          blank_lz,
    output logic [7:0]                    seg_data,
    output logic [NUM_CH*CH_DIGITS-1:0]   seg_an,
    output logic                          frame_done
);

    localparam int unsigned BcdW     = 4 * CH_DIGITS;
    localparam int unsigned NumSlots = NUM_CH * CH_DIGITS;
    localparam int unsigned ChW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PosW     = (CH_DIGITS > 1) ? $clog2(CH_DIGITS) : 1;
    localparam int unsigned SlotW    = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam int unsigned CntW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned PreW     = $clog2(REFRESH_DIV);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] MaxDec = pow10(CH_DIGITS) - 64'd1;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {StLoad, StShift, StStore} state_e;

    state_e              state_q, state_d;
    logic [ChW-1:0]      ch_idx_q, ch_idx_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic                mode_q, mode_d;
    logic                ovf_q, ovf_d;
    logic [BcdW-1:0]     bcd_q, bcd_d;
    logic [BcdW-1:0]     disp_dig_q [NUM_CH];
    logic [BcdW-1:0]     disp_dig_d [NUM_CH];
    logic [NUM_CH-1:0]   disp_ovf_q, disp_ovf_d;
    logic [NUM_CH-1:0]   disp_hex_q, disp_hex_d;
    logic [PreW-1:0]     pre_q, pre_d;
    logic [SlotW-1:0]    scan_q, scan_d;
    logic [7:0]          seg_q, seg_d;
    logic [NumSlots-1:0] an_q, an_d;

    logic [DATA_W-1:0]   ch_sel;
    logic [BcdW-1:0]     bcd_adj;
    logic [ChW-1:0]      sel_ch;
    logic [PosW-1:0]     sel_pos;
    logic [BcdW-1:0]     sel_dig;
    logic [3:0]          nib;
    logic                hi_zero;

    assign ch_sel = ch_data[ch_idx_q*DATA_W +: DATA_W];

    always_comb begin
        state_d    = state_q;
        ch_idx_d   = ch_idx_q;
        cnt_d      = cnt_q;
        val_d      = val_q;
        mode_d     = mode_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        disp_dig_d = disp_dig_q;
        disp_ovf_d = disp_ovf_q;
        disp_hex_d = disp_hex_q;

        bcd_adj = bcd_q;
        for (int d = 0; d < int'(CH_DIGITS); d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end

        unique case (state_q)
            StLoad: begin
                val_d   = ch_sel;
                mode_d  = hex_mode;
                bcd_d   = '0;
                cnt_d   = '0;
                ovf_d   = hex_mode ? ((ch_sel >> BcdW) != '0) : (64'(ch_sel) > MaxDec);
                state_d = hex_mode ? StStore : StShift;
            end
            StShift: begin
                bcd_d = {bcd_adj[BcdW-2:0], val_q[DATA_W-1]};
                val_d = val_q << 1;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(DATA_W - 1)) begin
                    state_d = StStore;
                end
            end
            StStore: begin
                // Digits, overflow and mode land together so the scanner never sees a mix.
                disp_dig_d[ch_idx_q] = mode_q ? BcdW'(val_q) : bcd_q;
                disp_ovf_d[ch_idx_q] = ovf_q;
                disp_hex_d[ch_idx_q] = mode_q;
                ch_idx_d = (ch_idx_q == ChW'(NUM_CH - 1)) ? '0 : ch_idx_q + ChW'(1);
                state_d  = StLoad;
            end
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        pre_d  = pre_q + PreW'(1);
        scan_d = scan_q;
        if (pre_q == PreW'(REFRESH_DIV - 1)) begin
            pre_d  = '0;
            scan_d = (scan_q == SlotW'(NumSlots - 1)) ? '0 : scan_q + SlotW'(1);
        end

        an_d         = '0;
        an_d[scan_q] = 1'b1;

        sel_ch  = '0;
        sel_pos = '0;
        for (int i = 0; i < int'(NumSlots); i++) begin
            if (scan_q == SlotW'(i)) begin
                sel_ch  = ChW'(i / int'(CH_DIGITS));
                sel_pos = PosW'(i % int'(CH_DIGITS));
            end
        end

        sel_dig = disp_dig_q[sel_ch];
        nib     = sel_dig[{sel_pos, 2'b00} +: 4];
        hi_zero = (sel_dig >> {sel_pos, 2'b00}) == '0;

        if (disp_ovf_q[sel_ch]) begin
            seg_d = 8'h40;
        end else if (blank_lz && (sel_pos != '0) && hi_zero) begin
            seg_d = 8'h00;
        end else begin
            seg_d = {disp_hex_q[sel_ch] && (sel_pos == '0), seg7(nib)};
        end
    end

    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StLoad;
            ch_idx_q   <= '0;
            cnt_q      <= '0;
            val_q      <= '0;
            mode_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                disp_dig_q[k] <= '0;
            end
            disp_ovf_q <= '0;
            disp_hex_q <= '0;
            pre_q      <= '0;
            scan_q     <= '0;
            seg_q      <= '0;
            an_q       <= '0;
        end else begin
            state_q    <= state_d;
            ch_idx_q   <= ch_idx_d;
            cnt_q      <= cnt_d;
            val_q      <= val_d;
            mode_q     <= mode_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            disp_dig_q <= disp_dig_d;
            disp_ovf_q <= disp_ovf_d;
            disp_hex_q <= disp_hex_d;
            pre_q      <= pre_d;
            scan_q     <= scan_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg_data   = seg_q;
    assign seg_an     = an_q;
    assign frame_done = (state_q == StStore) && (ch_idx_q == ChW'(NUM_CH - 1));

endmodule

// File: tb/tb_io_display_ctrl.sv
// Scoreboard bench for io_display_ctrl: directed vectors push per-slot expectations,
// a negedge monitor pops one whenever its digit enable is on the bus.
module tb_io_display_ctrl;

    localparam int NUM_CH      = 3;
    localparam int CH_DIGITS   = 2;
    localparam int DATA_W      = 32;
    localparam int REFRESH_DIV = 4;
    localparam int NSLOT       = NUM_CH * CH_DIGITS;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     hex_mode;
    logic                     blank_lz;
    logic [7:0]               seg_data;
    logic [NSLOT-1:0]         seg_an;
    logic                     frame_done;

    always #5 clk = ~clk;

    io_display_ctrl #(
        .NUM_CH     (NUM_CH),
        .CH_DIGITS  (CH_DIGITS),
        .DATA_W     (DATA_W),
        .REFRESH_DIV(REFRESH_DIV)
    ) dut (
        .sys_clk_in(clk),
        .sys_rst_n (rst_n),
        .ch_data   (ch_data),
        .hex_mode  (hex_mode),
        .blank_lz  (blank_lz),
        .seg_data  (seg_data),
        .seg_an    (seg_an),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [NSLOT-1:0] an;
        logic [7:0]       seg;
    } exp_t;

    // segs holds the expected code of slot s in bits [8*s +: 8].
    typedef struct packed {
        logic [31:0] c0;
        logic [31:0] c1;
        logic [31:0] c2;
        logic        hex;
        logic        blank;
        logic [47:0] segs;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && exp_q.size() > 0 && seg_an === exp_q[0].an) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (seg_data !== mon_e.seg) begin
                errors++;
                $display("FAIL scoreboard an=%02h: got %02h expected %02h",
                         mon_e.an, seg_data, mon_e.seg);
            end
        end
    end

    task automatic set_inputs(input int v);
        ch_data  = {vecs[v].c2, vecs[v].c1, vecs[v].c0};
        hex_mode = vecs[v].hex;
        blank_lz = vecs[v].blank;
    endtask

    task automatic wait_frame();
        bit got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(posedge clk);
            #1;
            if (frame_done === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout: got 0 expected 1");
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Two frame_done pulses guarantee every channel was sampled after the input change.
    task automatic apply(input int v);
        exp_t e;
        set_inputs(v);
        wait_frame();
        wait_frame();
        repeat (2) @(posedge clk);
        for (int s = 0; s < NSLOT; s++) begin
            e.an  = NSLOT'(1 << s);
            e.seg = vecs[v].segs[8*s +: 8];
            exp_q.push_back(e);
        end
        wait_drain();
    endtask

    task automatic check_reset_outputs();
        check("rst_seg_an", 32'(seg_an), 32'h0);
        check("rst_seg_data", 32'(seg_data), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
    endtask

    // Called right after reset release on a negedge; edge n is the n-th posedge after it.
    task automatic run_timing();
        int first_fd = -1;
        int fd_count = 0;
        for (int n = 1; n <= 110; n++) begin
            @(posedge clk);
            #1;
            if (frame_done === 1'b1) begin
                fd_count++;
                if (first_fd < 0) first_fd = n;
            end
            if (n <= 28) begin
                check("scan_an", 32'(seg_an), 32'(1 << (((n - 1) / 4) % NSLOT)));
            end
        end
        check("first_frame_done_edge", 32'(first_fd), 32'(NUM_CH * (DATA_W + 2) - 1));
        check("frame_done_pulses", 32'(fd_count), 32'd1);
    endtask

    initial begin
        vecs[0] = '{c0: 32'd37, c1: 32'd99, c2: 32'd0, hex: 1'b0, blank: 1'b0,
                    segs: 48'h3F3F_6F6F_4F07};
        vecs[1] = '{c0: 32'd42, c1: 32'd99, c2: 32'd0, hex: 1'b0, blank: 1'b0,
                    segs: 48'h3F3F_6F6F_665B};
        vecs[2] = '{c0: 32'd0, c1: 32'd100, c2: 32'd5, hex: 1'b0, blank: 1'b0,
                    segs: 48'h3F6D_4040_3F3F};
        vecs[3] = '{c0: 32'h05, c1: 32'h12C, c2: 32'h2C, hex: 1'b1, blank: 1'b0,
                    segs: 48'h5BB9_4040_3FED};
        vecs[4] = '{c0: 32'd5, c1: 32'd10, c2: 32'd0, hex: 1'b0, blank: 1'b1,
                    segs: 48'h003F_063F_006D};
        vecs[5] = '{c0: 32'd5, c1: 32'd10, c2: 32'd0, hex: 1'b0, blank: 1'b0,
                    segs: 48'h3F3F_063F_3F6D};
        vecs[6] = '{c0: 32'hBA, c1: 32'hDE, c2: 32'hF0, hex: 1'b1, blank: 1'b1,
                    segs: 48'h71BF_5EF9_7CF7};
        vecs[7] = '{c0: 32'hFFFF_FFFF, c1: 32'd42, c2: 32'd68, hex: 1'b0, blank: 1'b0,
                    segs: 48'h7D7F_665B_4040};
        vecs[8] = '{c0: 32'h3, c1: 32'h0, c2: 32'h100, hex: 1'b1, blank: 1'b1,
                    segs: 48'h4040_00BF_00CF};

        rst_n = 1'b1;
        set_inputs(0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_timing();

        apply(0);

        // ch0 changes mid-conversion; slots 0/1 must keep showing 37 until a later frame.
        begin
            int bad = 0;
            wait_frame();
            repeat (4) @(posedge clk);
            #1;
            ch_data[31:0] = 32'd42;
            for (int n = 0; n < 90; n++) begin
                @(negedge clk);
                if (seg_an == 6'h01 && seg_data !== 8'h07) bad++;
                if (seg_an == 6'h02 && seg_data !== 8'h4F) bad++;
            end
            check("hold_old_value", 32'(bad), 32'd0);
        end
        apply(1);

        for (int v = 2; v < 9; v++) begin
            apply(v);
        end

        set_inputs(0);
        wait_frame();
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_timing();
        apply(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_display_ctrl.md
Name: io_display_ctrl

Overview:
Parametrised multi-channel numeric display controller for the IO test top level. It samples NUM_CH binary values, such as CPU out ports and input ports. Each value is converted to CH_DIGITS decimal digits with a sequential double-dabble engine, or passed through as hex nibbles. The block then time-multiplexes all digits onto one seven-segment bus. It adds leading-zero blanking, overflow indication and a per-frame update strobe.

Parameters:
NUM_CH, 3, number of value channels
CH_DIGITS, 2, digits per channel (1..8)
DATA_W, 32, width of each channel value
REFRESH_DIV, 100000, sys_clk_in cycles per digit scan slot (>=2)

Ports:
sys_clk_in  input  1  system clock, rising edge
sys_rst_n  input  1  asynchronous active-low reset
ch_data  input  NUM_CH*DATA_W  channel values; channel k = bits [k*DATA_W +: DATA_W]
hex_mode  input  1  1 = hexadecimal display, 0 = decimal
blank_lz  input  1  1 = blank leading zeros
seg_data  output  8  {dp,g,f,e,d,c,b,a}, 1 = segment lit
seg_an  output  NUM_CH*CH_DIGITS  one-hot digit enable, active high; bit 0 = least significant digit of channel 0
frame_done  output  1  one-cycle pulse when the last channel's display register is written

Behaviour:
- Reset (async, sys_rst_n=0): seg_data=0, seg_an=0, frame_done=0, all display registers = 0 with overflow flags clear, FSM=LOAD, channel index=0, prescaler=0, scan index=0.
- Converter FSM, round-robin over channels 0..NUM_CH-1:
  - LOAD (1 cycle): latch the channel value and hex_mode, clear the BCD shift register, compute the overflow flag.
    - Decimal overflow: value > 10^CH_DIGITS-1.
    - Hex overflow: any bit at or above 4*CH_DIGITS is nonzero.
    - Next state is SHIFT if decimal, STORE if hex.
  - SHIFT (DATA_W cycles): each cycle, add 3 to every BCD nibble >=5, then shift left one bit, with the value MSB entering.
  - STORE (1 cycle): write the digits and overflow flag atomically into that channel's display register, advance the channel index (wrap to 0), then go to LOAD. frame_done=1 in this cycle only when the channel index is NUM_CH-1.
- Conversion latency: DATA_W+2 cycles per channel in decimal, 2 cycles in hex. Decimal frame = NUM_CH*(DATA_W+2) cycles.
- Input and mode sampling:
  - ch_data and hex_mode are sampled only at LOAD. Changes during SHIFT do not affect the conversion in progress.
  - The display shows the old value until STORE, so digits never tear.
- Scanner:
  - The prescaler counts 0..REFRESH_DIV-1. On terminal count, the scan index increments, wrapping from NUM_CH*CH_DIGITS-1 to 0.
  - seg_an = one-hot(scan index), registered. seg_data is registered in the same cycle as seg_an, so both are aligned.
  - The first slot after reset shows digit 0 from cycle 1.
- Digit mapping: scan index i maps to channel i/CH_DIGITS, position p = i%CH_DIGITS, where p=0 is least significant.
- Segment codes for nibbles 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Priority, highest first:
  1. Channel overflow: digit shows 40 (dash) at every position.
  2. Blanking: blank_lz=1, p>0, and all digits of that channel at positions >= p are 0. Digit shows 00.
  3. Otherwise the digit's segment code is shown.
- Decimal point: dp=1 on position 0 of every channel when the stored mode for that channel is hex. This is not applied on overflow.
- blank_lz is combinational into the registered seg_data path and takes effect on the next clock.
- Position 0 is never blanked, so a value of 0 displays 3F.

Test Plan:
1. Reset: hold sys_rst_n=0 for 5 cycles mid-operation -> seg_an=0, seg_data=0, frame_done=0 immediately (asynchronously). After release, with DATA_W=32 and NUM_CH=3 in decimal mode, the first frame_done pulse comes 102 cycles after the first edge, lasting 1 cycle.
2. Decimal: ch0=37, hex_mode=0, blank_lz=0 -> seg_an=0x01 gives seg_data=07; seg_an=0x02 gives 4F. ch0=0 -> 3F at both positions.
3. Overflow: ch1=100, CH_DIGITS=2 -> seg_an 0x04 and 0x08 both give 40. ch1=99 -> 6F, 6F.
4. Hex: hex_mode=1, ch2=0x2C -> seg_an 0x10 gives B9 (39 with dp), seg_an 0x20 gives 5B. ch2=0x12C -> 40, 40.
5. Blanking: ch0=5. blank_lz=1 -> pos1 gives 00, pos0 gives 6D. blank_lz=0 -> pos1 gives 3F.
6. Scan and stability: REFRESH_DIV=4 -> seg_an steps 01,02,04,08,10,20,01 every 4 cycles. Change ch0 from 37 to 42 during ch0 SHIFT -> display stays 37 until the next ch0 STORE, with no intermediate digit values.
